// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller and its hazard scoreboard.
package pipe_ctrl_pkg;

  localparam int INST_W           = 19;
  localparam int REG_W            = 3;
  localparam int SCOREBOARD_DEPTH = 3;

  // Register field positions inside an instruction word
  localparam int RD_LSB  = 11;
  localparam int RS1_LSB = 8;
  localparam int RS2_LSB = 5;

  localparam logic [INST_W-1:0] HALT_INST = 19'h00001;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_STALL,
    ST_DRAIN,
    ST_HALTED,
    ST_FAULT
  } state_t;

  // One in-flight destination register: slot 0 = ID, 1 = EX, 2 = MEM
  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] rd;
  } sb_entry_t;

  function automatic logic [REG_W-1:0] reg_field(input logic [INST_W-1:0] inst,
                                                 input int lsb);
    return inst[lsb +: REG_W];
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Tracks destination registers of instructions in ID/EX/MEM and flags RAW hazards
// for the instruction sitting in IF.
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  sb_entry_t        push,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs1_live,
  input  logic             rs2_live,
  output logic             hazard,
  output logic             drain_done
);

  sb_entry_t [SCOREBOARD_DEPTH-1:0] slot;
  logic      [SCOREBOARD_DEPTH-1:0] hit;

  // Shift one slot per cycle; the oldest entry retires out of MEM
  always_ff @(posedge clk) begin
    if (rst) slot <= '0;
    else     slot <= {slot[SCOREBOARD_DEPTH-2:0], push};
  end

  // Per-slot RAW compare; no forwarding, so every valid slot can block
  for (genvar g = 0; g < SCOREBOARD_DEPTH; g++) begin : g_cmp
    assign hit[g] = slot[g].vld &&
                    ((rs1_live && (slot[g].rd == rs1)) ||
                     (rs2_live && (slot[g].rd == rs2)));
  end

  assign hazard = |hit;

  // Only the MEM slot may still be occupied: after this edge the pipe is empty
  always_comb begin
    drain_done = 1'b1;
    for (int i = 0; i < SCOREBOARD_DEPTH - 1; i++)
      if (slot[i].vld) drain_done = 1'b0;
  end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline control: RAW stalls, redirect flushes, halt drain and overflow fault.
module pipeline_controller
  import pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] if_inst,
  input  logic              if_rs2_sel,
  input  logic              if_reads_rs1,
  input  logic              if_reads_rs2,
  input  logic              if_reg_write,
  input  logic              redirect,
  input  logic              stack_overflow,
  output logic              pc_write,
  output logic              if_write,
  output logic              id_bubble,
  output logic              flush_if,
  output logic              flush_id,
  output logic              halted,
  output logic              fault,
  output logic [15:0]       stall_count
);

  state_t           state, nxt_state;
  logic             hazard, drain_done, cnt_inc, is_halt;
  logic [REG_W-1:0] rs1, rs2;
  sb_entry_t        push;

  assign rs1     = reg_field(if_inst, RS1_LSB);
  assign rs2     = if_rs2_sel ? reg_field(if_inst, RD_LSB) : reg_field(if_inst, RS2_LSB);
  assign is_halt = (if_inst == HALT_INST);

  // The IF instruction enters ID only when it really advances
  assign push.vld = if_reg_write & if_write & ~id_bubble & ~flush_id;
  assign push.rd  = reg_field(if_inst, RD_LSB);

  hazard_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1_live   (if_reads_rs1),
    .rs2_live   (if_reads_rs2),
    .hazard     (hazard),
    .drain_done (drain_done)
  );

  assign halted = (state == ST_HALTED) & ~rst;
  assign fault  = (state == ST_FAULT)  & ~rst;

  // Next state and control outputs, in priority order overflow > redirect > halt > hazard.
  // STALL accepts a halt like RUN does, otherwise a halt leaving a stall would slip into ID.
  always_comb begin
    pc_write  = 1'b1;
    if_write  = 1'b1;
    id_bubble = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    cnt_inc   = 1'b0;
    nxt_state = state;
    if (rst) begin
      nxt_state = ST_RUN;
    end else if (state == ST_FAULT) begin
      pc_write = 1'b0; if_write = 1'b0; id_bubble = 1'b1;
    end else if (stack_overflow) begin
      pc_write = 1'b0; if_write = 1'b0; id_bubble = 1'b1;
      nxt_state = ST_FAULT;
    end else if (state == ST_HALTED) begin
      pc_write = 1'b0; if_write = 1'b0; id_bubble = 1'b1;
    end else if (redirect) begin
      flush_if = 1'b1; flush_id = 1'b1;
      nxt_state = ST_RUN;
    end else if (state == ST_DRAIN) begin
      pc_write = 1'b0; if_write = 1'b0; id_bubble = 1'b1;
      if (drain_done) nxt_state = ST_HALTED;
    end else if (is_halt) begin
      pc_write = 1'b0; if_write = 1'b0; id_bubble = 1'b1;
      nxt_state = ST_DRAIN;
    end else if (hazard) begin
      pc_write = 1'b0; if_write = 1'b0; id_bubble = 1'b1;
      cnt_inc   = 1'b1;
      nxt_state = ST_STALL;
    end else begin
      nxt_state = ST_RUN;
    end
  end

  // State register and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      stall_count <= '0;
    end else begin
      state <= nxt_state;
      if (cnt_inc && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller with a per-cycle reference model.
module tb_pipeline_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] if_inst;
  logic        if_rs2_sel, if_reads_rs1, if_reads_rs2, if_reg_write;
  logic        redirect, stack_overflow;
  logic        pc_write, if_write, id_bubble, flush_if, flush_id, halted, fault;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  localparam logic [18:0] HALT = 19'h00001;

  pipeline_controller dut (
    .clk            (clk),
    .rst            (rst),
    .if_inst        (if_inst),
    .if_rs2_sel     (if_rs2_sel),
    .if_reads_rs1   (if_reads_rs1),
    .if_reads_rs2   (if_reads_rs2),
    .if_reg_write   (if_reg_write),
    .redirect       (redirect),
    .stack_overflow (stack_overflow),
    .pc_write       (pc_write),
    .if_write       (if_write),
    .id_bubble      (id_bubble),
    .flush_if       (flush_if),
    .flush_id       (flush_id),
    .halted         (halted),
    .fault          (fault),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [18:0] mk(input int rd, input int rs1, input int rs2);
    return 19'((rd << 11) | (rs1 << 8) | (rs2 << 5));
  endfunction

  // Model: pipeline is running, draining, halted or faulted; in-flight writers
  // are kept as (rd, cycles left before the write lands) pairs.
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2, M_FAULT = 3;
  int mode = M_RUN;
  int cnt  = 0;
  int pend_rd[$];
  int pend_left[$];

  initial begin : model
    int e_pc, e_ifw, e_bub, e_fl, e_hlt, e_flt, nmode, inc, r1, r2, haz, gone, issue, wrd;
    forever begin
      @(negedge clk);
      e_pc = 1; e_ifw = 1; e_bub = 0; e_fl = 0; nmode = mode; inc = 0;
      e_hlt = (!rst && mode == M_HALT);
      e_flt = (!rst && mode == M_FAULT);
      r1 = (if_inst >> 8) & 7;
      r2 = if_rs2_sel ? ((if_inst >> 11) & 7) : ((if_inst >> 5) & 7);
      haz = 0;
      foreach (pend_rd[k])
        if ((if_reads_rs1 && pend_rd[k] == r1) || (if_reads_rs2 && pend_rd[k] == r2)) haz = 1;
      gone = 1;
      foreach (pend_left[k]) if (pend_left[k] > 1) gone = 0;
      if (rst) begin
        nmode = M_RUN;
      end else if (mode == M_FAULT) begin
        e_pc = 0; e_ifw = 0; e_bub = 1;
      end else if (stack_overflow) begin
        e_pc = 0; e_ifw = 0; e_bub = 1; nmode = M_FAULT;
      end else if (mode == M_HALT) begin
        e_pc = 0; e_ifw = 0; e_bub = 1;
      end else if (redirect) begin
        e_fl = 1; nmode = M_RUN;
      end else if (mode == M_DRAIN) begin
        e_pc = 0; e_ifw = 0; e_bub = 1;
        if (gone) nmode = M_HALT;
      end else if (if_inst == HALT) begin
        e_pc = 0; e_ifw = 0; e_bub = 1; nmode = M_DRAIN;
      end else if (haz) begin
        e_pc = 0; e_ifw = 0; e_bub = 1; inc = 1;
      end
      issue = !rst && e_ifw && !e_bub && !e_fl && if_reg_write;
      wrd   = (if_inst >> 11) & 7;
      chk("pc_write",    pc_write,    e_pc);
      chk("if_write",    if_write,    e_ifw);
      chk("id_bubble",   id_bubble,   e_bub);
      chk("flush_if",    flush_if,    e_fl);
      chk("flush_id",    flush_id,    e_fl);
      chk("halted",      halted,      e_hlt);
      chk("fault",       fault,       e_flt);
      chk("stall_count", stall_count, cnt);
      @(posedge clk);
      if (rst) begin
        pend_rd.delete(); pend_left.delete(); mode = M_RUN; cnt = 0;
      end else begin
        for (int k = pend_left.size() - 1; k >= 0; k--) begin
          pend_left[k]--;
          if (pend_left[k] == 0) begin pend_left.delete(k); pend_rd.delete(k); end
        end
        if (issue) begin pend_rd.push_back(wrd); pend_left.push_back(3); end
        mode = nmode;
        if (inc && cnt < 65535) cnt++;
      end
    end
  end

  // Drive one cycle of inputs just after the edge, return mid-cycle for sampling
  task automatic step(input logic [18:0] i, input logic sel, input logic r1, input logic r2,
                      input logic wr, input logic rd_, input logic ov, input logic rs);
    @(posedge clk); #1;
    if_inst = i; if_rs2_sel = sel; if_reads_rs1 = r1; if_reads_rs2 = r2;
    if_reg_write = wr; redirect = rd_; stack_overflow = ov; rst = rs;
    @(negedge clk);
  endtask

  task automatic nops(input int n);
    for (int k = 0; k < n; k++) step(19'd0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : stim
    int bub_n;
    rst = 1'b1; if_inst = '0; if_rs2_sel = 0; if_reads_rs1 = 0; if_reads_rs2 = 0;
    if_reg_write = 0; redirect = 0; stack_overflow = 0;
    step(19'd0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_pc_write", pc_write, 1);
    nops(1);
    chk("reset_stall_count", stall_count, 0);
    chk("reset_halted", halted, 0);

    // A: rd=3 writer then rs1=3 reader -> three bubbles
    step(mk(3, 0, 0), 0, 0, 0, 1, 0, 0, 0);
    bub_n = 0;
    for (int k = 0; k < 4; k++) begin
      step(mk(0, 3, 0), 0, 1, 0, 0, 0, 0, 0);
      bub_n += int'(id_bubble);
    end
    chk("a_bubbles", bub_n, 3);
    chk("a_stall_count", stall_count, 3);
    nops(3);

    // B: rs2 via [7:5] stalls, via [13:11]=5 does not
    step(mk(3, 0, 0), 0, 0, 0, 1, 0, 0, 0);
    step(mk(0, 0, 3), 0, 0, 1, 0, 0, 0, 0);
    chk("b_rs2_stall", id_bubble, 1);
    for (int k = 0; k < 3; k++) step(mk(0, 0, 3), 0, 0, 1, 0, 0, 0, 0);
    chk("b_stall_count", stall_count, 6);
    nops(3);
    step(mk(3, 0, 0), 0, 0, 0, 1, 0, 0, 0);
    step(mk(5, 0, 3), 1, 0, 1, 0, 0, 0, 0);
    chk("b_sel1_no_stall", id_bubble, 0);
    nops(3);

    // C: hazard and redirect together -> flush wins, no count
    step(mk(3, 0, 0), 0, 0, 0, 1, 0, 0, 0);
    step(mk(0, 3, 0), 0, 1, 0, 0, 1, 0, 0);
    chk("c_flush_if", flush_if, 1);
    chk("c_flush_id", flush_id, 1);
    chk("c_pc_write", pc_write, 1);
    nops(1);
    chk("c_stall_count", stall_count, 6);
    nops(3);

    // D: halt behind two writers -> 2 drain cycles then halted forever
    step(mk(1, 0, 0), 0, 0, 0, 1, 0, 0, 0);
    step(mk(2, 0, 0), 0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step(HALT, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("d_halted_%0d", k), halted, (k >= 3) ? 1 : 0);
      chk($sformatf("d_pc_write_%0d", k), pc_write, 0);
    end
    step(HALT, 0, 0, 0, 0, 1, 0, 0);
    chk("d_terminal_halted", halted, 1);
    step(19'd0, 0, 0, 0, 0, 0, 0, 1);
    chk("d_rst_halted", halted, 0);

    // E: halt then redirect -> back to RUN
    step(HALT, 0, 0, 0, 0, 0, 0, 0);
    step(19'd0, 0, 0, 0, 0, 1, 0, 0);
    chk("e_flush_if", flush_if, 1);
    nops(3);
    chk("e_halted", halted, 0);
    chk("e_pc_write", pc_write, 1);

    // F: overflow pulse -> sticky fault until reset
    step(19'd0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(19'd0, 0, 0, 0, 0, (k == 1) ? 1'b1 : 1'b0, 0, 0);
      chk($sformatf("f_fault_%0d", k), fault, 1);
      chk($sformatf("f_pc_write_%0d", k), pc_write, 0);
    end
    step(19'd0, 0, 0, 0, 0, 0, 0, 1);
    chk("f_rst_pc_write", pc_write, 1);
    chk("f_rst_if_write", if_write, 1);
    chk("f_rst_id_bubble", id_bubble, 0);
    chk("f_rst_fault", fault, 0);
    nops(1);
    chk("f_post_fault", fault, 0);
    chk("f_post_count", stall_count, 0);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
